// File: rtl/bcd_to_binary_seq_if.sv
// Start/done handshake, BCD digit inputs and result outputs of the BCD-to-binary converter.
interface bcd_to_binary_seq_if #(
    parameter int unsigned OUT_WIDTH = 32
);
    logic                 start;
    logic [3:0]           mille;
    logic [3:0]           hundreds;
    logic [3:0]           tens;
    logic [3:0]           ones;
    logic [OUT_WIDTH-1:0] number;
    logic                 busy;
    logic                 done;
    logic                 error;

    // Requester side: issues start and digits, observes the result.
    modport master (
        output start, mille, hundreds, tens, ones,
        input  number, busy, done, error
    );

    // Converter side.
    modport slave (
        input  start, mille, hundreds, tens, ones,
        output number, busy, done, error
    );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter: reverse double-dabble, one shift/correct step per clock.
// The digit ports are fixed at four nibbles (thousands..ones), so DIGITS must be left at 4.
module bcd_to_binary_seq #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned BIN_BITS  = 14,
    parameter int unsigned OUT_WIDTH = 32
) (
    input logic              clock,
    input logic              reset,
    bcd_to_binary_seq_if.slave bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_BITS;
    localparam int unsigned CNT_W = $clog2(BIN_BITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SR_W-1:0]      sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] number_q, number_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 bad_q, bad_d;

    logic [SR_W-1:0]      sr_shift_c;
    logic [SR_W-1:0]      sr_step_c;
    logic                 digit_bad_c;

    // One conversion step: logical right shift, then subtract 3 from every BCD nibble >= 8.
    always_comb begin
        sr_shift_c = sr_q >> 1;
        sr_step_c  = sr_shift_c;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sr_shift_c[BIN_BITS + 4*i + 3]) begin
                sr_step_c[BIN_BITS + 4*i +: 4] = sr_shift_c[BIN_BITS + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Any captured digit above 9 makes the whole request invalid.
    always_comb begin
        digit_bad_c = (bus.mille > 4'd9) | (bus.hundreds > 4'd9) |
                      (bus.tens  > 4'd9) | (bus.ones     > 4'd9);
    end

    // Next-state and next-output logic; results are published on the DONE cycle together with done.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        number_d = number_q;
        error_d  = error_q;
        bad_d    = bad_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d    = {BCD_W'({bus.mille, bus.hundreds, bus.tens, bus.ones}),
                               {BIN_BITS{1'b0}}};
                    cnt_d   = '0;
                    bad_d   = digit_bad_c;
                    state_d = digit_bad_c ? DONE : CONV;
                end
            end
            CONV: begin
                sr_d  = sr_step_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_BITS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d   = 1'b1;
                error_d  = bad_q;
                number_d = bad_q ? '0 : OUT_WIDTH'(sr_q[BIN_BITS-1:0]);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            number_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            number_q <= number_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            bad_q    <= bad_d;
        end
    end

    assign bus.number = number_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.error  = error_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq: vector table, random digits vs. arithmetic model, corner sequences.
module tb_bcd_to_binary_seq;
    localparam int unsigned BIN_BITS = 14;
    localparam int          LAT_OK   = BIN_BITS + 1;
    localparam int          LAT_BAD  = 1;
    localparam int          PERIOD   = BIN_BITS + 2;

    logic clock = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    bcd_to_binary_seq_if #(.OUT_WIDTH(32)) bus ();

    bcd_to_binary_seq #(
        .DIGITS   (4),
        .BIN_BITS (BIN_BITS),
        .OUT_WIDTH(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  m;
        logic [3:0]  h;
        logic [3:0]  t;
        logic [3:0]  o;
        logic [31:0] num;
        logic        err;
        int          lat;
    } vec_t;

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    // Reference: decimal value by plain arithmetic, zero with error on any non-decimal digit.
    task automatic ref_conv(input logic [3:0] m, h, t, o, output logic [31:0] num, output logic err);
        err = (m > 9) || (h > 9) || (t > 9) || (o > 9);
        num = err ? 32'd0 : (32'(m) * 1000 + 32'(h) * 100 + 32'(t) * 10 + 32'(o));
    endtask

    task automatic set_digits(input logic [3:0] m, h, t, o);
        bus.mille    = m;
        bus.hundreds = h;
        bus.tens     = t;
        bus.ones     = o;
    endtask

    // One full start->done transaction with latency, busy, result and pulse-width checks.
    task automatic run_conv(input string nm, input logic [3:0] m, h, t, o,
                            input logic [31:0] exp_num, input logic exp_err, input int exp_lat);
        int lat;
        int busy_cnt;
        set_digits(m, h, t, o);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        set_digits(4'hF, 4'hF, 4'hF, 4'hF);
        busy_cnt = bus.busy ? 1 : 0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        if (lat > 0) begin
            chk({nm, " number"}, bus.number, exp_num);
            chk({nm, " error"}, 32'(bus.error), 32'(exp_err));
            chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
            step();
            chk({nm, " done_width"}, 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        vec_t        vecs[8];
        logic [31:0] rnum;
        logic        rerr;
        logic [3:0]  d[4];
        int          ndone;
        int          last_done;

        vecs[0] = '{4'd0, 4'd0, 4'd0, 4'd0, 32'h0000_0000, 1'b0, LAT_OK};
        vecs[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 32'h0000_270F, 1'b0, LAT_OK};
        vecs[2] = '{4'd1, 4'd2, 4'd3, 4'd4, 32'h0000_04D2, 1'b0, LAT_OK};
        vecs[3] = '{4'd0, 4'd0, 4'd0, 4'd7, 32'd7,         1'b0, LAT_OK};
        vecs[4] = '{4'd1, 4'hA, 4'd0, 4'd0, 32'd0,         1'b1, LAT_BAD};
        vecs[5] = '{4'd0, 4'd0, 4'd4, 4'd2, 32'd42,        1'b0, LAT_OK};
        vecs[6] = '{4'hF, 4'hF, 4'hF, 4'hF, 32'd0,         1'b1, LAT_BAD};
        vecs[7] = '{4'd8, 4'd0, 4'd0, 4'd8, 32'd8008,      1'b0, LAT_OK};

        reset     = 1'b1;
        bus.start = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("reset number", bus.number, 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset error", 32'(bus.error), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].m, vecs[i].h, vecs[i].t, vecs[i].o,
                     vecs[i].num, vecs[i].err, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 4; j++) begin
                d[j] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 9));
            end
            ref_conv(d[0], d[1], d[2], d[3], rnum, rerr);
            run_conv($sformatf("rand%0d_%h%h%h%h", i, d[0], d[1], d[2], d[3]),
                     d[0], d[1], d[2], d[3], rnum, rerr, rerr ? LAT_BAD : LAT_OK);
        end

        // Start held high: one conversion per PERIOD cycles; mid-CONV digit changes are ignored.
        ndone     = 0;
        last_done = -1;
        bus.start = 1'b1;
        for (int c = 0; c < 3 * PERIOD; c++) begin
            if ((c % PERIOD) >= 4 && (c % PERIOD) <= 10) set_digits(4'd1, 4'd1, 4'd1, 4'd1);
            else                                          set_digits(4'd5, 4'd0, 4'd0, 4'd0);
            step();
            if (bus.done) begin
                ndone++;
                chk($sformatf("held number%0d", ndone), bus.number, 32'd5000);
                chk($sformatf("held done_at%0d", ndone), 32'(c), 32'(ndone * PERIOD - 1));
                if (last_done >= 0) chk("held spacing", 32'(c - last_done), 32'(PERIOD));
                last_done = c;
            end
        end
        bus.start = 1'b0;
        chk("held done_count", 32'(ndone), 32'd3);
        step();

        // Reset after step 7 of 9876 aborts without a done pulse.
        set_digits(4'd9, 4'd8, 4'd7, 4'd6);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 7; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort number", bus.number, 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.done) ndone++;
        end
        chk("abort no_done", 32'(ndone), 32'd0);
        run_conv("after_abort", 4'd9, 4'd8, 4'd7, 4'd6, 32'h0000_2694, 1'b0, LAT_OK);

        // Start pulses during CONV and DONE are ignored.
        set_digits(4'd3, 4'd2, 4'd1, 4'd0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5 || k == LAT_OK) begin
                bus.start = 1'b1;
                set_digits(4'd7, 4'd7, 4'd7, 4'd7);
            end else begin
                bus.start = 1'b0;
            end
            step();
            if (bus.done) begin
                ndone++;
                chk("busy_start number", bus.number, 32'd3210);
                chk("busy_start latency", 32'(k), 32'(LAT_OK));
            end
        end
        chk("busy_start done_count", 32'(ndone), 32'd1);
        chk("busy_start idle", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute backstop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
Sequential BCD-to-binary converter using reverse double-dabble (shift right, subtract-3). It is the inverse of the team's combinational binary-to-BCD display path.
It converts a 4-digit decimal value (thousands/hundreds/tens/ones), e.g. entered on board switches, into a 32-bit zero-extended word for the MIPS datapath or I/O register.
It uses a start/done handshake and processes one shift step per clock.

Parameters:
DIGITS, 4, number of BCD input digits.
BIN_BITS, 14, binary result width and number of conversion steps; must be >= ceil(DIGITS*log2(10)) (14 for 9999).
OUT_WIDTH, 32, width of the number output; the result is zero-extended from BIN_BITS.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request conversion; sampled only in IDLE.
mille  input  4  thousands BCD digit.
hundreds  input  4  hundreds BCD digit.
tens  input  4  tens BCD digit.
ones  input  4  ones BCD digit.
number  output  OUT_WIDTH  binary result; registered; holds the last result.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse when number/error update.
error  output  1  set if any captured digit > 9; holds until the next completion.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, number=0, busy=0, done=0, error=0, step counter=0, shift register=0. Reset overrides every other input, including mid-conversion; an aborted conversion never asserts done.
- States: IDLE, CONV, DONE.
- IDLE, start=0: remain in IDLE; outputs hold.
- IDLE, start=1 at edge t: capture the digits into shift register SR = {mille,hundreds,tens,ones, BIN_BITS zeros} (16+BIN_BITS bits); count=0.
  - If any digit > 9: next state DONE with number=0, error=1.
  - Otherwise: next state CONV.
- CONV step, one per cycle:
  - SR = SR >> 1 (logical).
  - Then, independently for each BCD nibble of the shifted SR: if nibble >= 8, subtract 3 (4-bit).
  - count += 1.
  - After step BIN_BITS (count reaches BIN_BITS): number = zero-extend(SR[BIN_BITS-1:0]), error=0, next state DONE.
- DONE: done=1 for exactly this one cycle; next state IDLE. Start is ignored in DONE; a new start is accepted from the following IDLE cycle.
- Valid latency: start sampled at edge t -> done high in the cycle following edge t+BIN_BITS+1 (15 edges for the default). Back-to-back throughput is one conversion per BIN_BITS+2 cycles.
- Invalid latency: done high after edge t+1; number=0, error=1.
- Start while busy (CONV or DONE): ignored. Digit inputs are don't-care after capture; changes mid-conversion do not affect the result.
- number, error and done are registered; there is no combinational path from inputs to outputs.
- Arithmetic: nibble correction is modulo-16. A valid digit never underflows, since correction applies only to nibbles >= 8.
- Maximum valid result is 9999 = 0x0000270F; the upper OUT_WIDTH-BIN_BITS bits are always 0.

Test Plan:
- Reset, then start with digits 0,0,0,0 -> done pulse 15 edges after start; number=0x00000000; error=0; busy high for exactly 15 cycles.
- Digits 9,9,9,9 -> number=0x0000270F (9999); digits 1,2,3,4 -> number=0x000004D2 (1234); digits 0,0,0,7 -> number=7.
- Digits 1,0xA,0,0 -> done one cycle after start; error=1; number=0. A following valid conversion of 0,0,4,2 -> number=42 and error cleared to 0.
- Start held high continuously with digits 5,0,0,0 -> exactly one conversion per 16 cycles; done pulses are 16 cycles apart; number=5000 each time. Changing the digits to 1,1,1,1 mid-CONV does not alter the in-flight result.
- Assert reset at step 7 of a 9,8,7,6 conversion -> next cycle IDLE; number=0, busy=0; no done pulse. A fresh start then yields 9876 (0x2694).
- Start pulsed while busy -> ignored; only the original conversion completes with one done pulse.
